// File: rtl/audio_playback_mixer.sv
// Multi-channel mixer: priority select or average mix, gain, saturation, and a first-order PDM output.
// Optional clip_out pulse is built only when MIXER_CLIP_DETECT_EN is defined.
module audio_playback_mixer #(
   parameter int NUM_CHANNELS = 4,
   parameter int SAMPLE_WIDTH = 16
) (
   input  logic                                      clk_in,
   input  logic                                      rst_in,
   input  logic [NUM_CHANNELS-1:0][SAMPLE_WIDTH-1:0] audio_data_in,
   input  logic                                      audio_valid_in,
   output logic                                      audio_ready_out,
   input  logic [NUM_CHANNELS-1:0]                   sel_in,
   input  logic                                      mode_in,
   input  logic [2:0]                                gain_in,
   output logic [SAMPLE_WIDTH-1:0]                   level_out,
   output logic                                      level_valid_out,
   output logic                                      pdm_out
`ifdef MIXER_CLIP_DETECT_EN
   ,
   output logic                                      clip_out
`endif
);

   localparam int LOG2_CH = $clog2(NUM_CHANNELS);
   localparam int ACC_W   = SAMPLE_WIDTH + LOG2_CH + 8;
   localparam int RES_W   = ACC_W + 8;
   localparam logic [LOG2_CH-1:0] LAST_IDX = LOG2_CH'(NUM_CHANNELS - 1);
   localparam logic signed [RES_W-1:0] SAT_MAX = RES_W'((1 << (SAMPLE_WIDTH - 1)) - 1);
   localparam logic signed [RES_W-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {IDLE, ACCUM, SCALE} state_e;

   state_e                                   state_q, state_d;
   logic [LOG2_CH-1:0]                       idx_q, idx_d;
   logic signed [ACC_W-1:0]                  acc_q, acc_d;
   logic                                     found_q, found_d;
   logic [NUM_CHANNELS-1:0][SAMPLE_WIDTH-1:0] data_q, data_d;
   logic [NUM_CHANNELS-1:0]                  sel_q, sel_d;
   logic                                     mode_q, mode_d;
   logic [2:0]                               gain_q, gain_d;
   logic                                     ready_q, ready_d;
   logic [SAMPLE_WIDTH-1:0]                  level_q, level_d;
   logic                                     level_vld_q, level_vld_d;
   logic [SAMPLE_WIDTH-1:0]                  pdm_acc_q, pdm_acc_d;
   logic                                     pdm_q, pdm_d;

   logic [SAMPLE_WIDTH-1:0]   cur_sample;
   logic signed [ACC_W-1:0]   cur_ext;
   logic signed [RES_W-1:0]   acc_ext, shifted, scaled;
   logic                      sat_hi, sat_lo;
   logic [SAMPLE_WIDTH-1:0]   sat_val;
   logic [SAMPLE_WIDTH:0]     pdm_sum;

   assign cur_sample = data_q[idx_q];
   assign cur_ext    = {{(ACC_W - SAMPLE_WIDTH){cur_sample[SAMPLE_WIDTH-1]}}, cur_sample};

   // Widen before shifting so gain never wraps ahead of the saturation check.
   assign acc_ext = {{8{acc_q[ACC_W-1]}}, acc_q};
   assign shifted = mode_q ? (acc_ext >>> LOG2_CH) : acc_ext;
   assign scaled  = shifted <<< gain_q;
   assign sat_hi  = scaled > SAT_MAX;
   assign sat_lo  = scaled < SAT_MIN;
   assign sat_val = sat_hi ? SAT_MAX[SAMPLE_WIDTH-1:0] :
                    sat_lo ? SAT_MIN[SAMPLE_WIDTH-1:0] : scaled[SAMPLE_WIDTH-1:0];

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      acc_d       = acc_q;
      found_d     = found_q;
      data_d      = data_q;
      sel_d       = sel_q;
      mode_d      = mode_q;
      gain_d      = gain_q;
      ready_d     = ready_q;
      level_d     = level_q;
      level_vld_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (audio_valid_in && ready_q) begin
               data_d  = audio_data_in;
               sel_d   = sel_in;
               mode_d  = mode_in;
               gain_d  = gain_in;
               acc_d   = '0;
               found_d = 1'b0;
               idx_d   = '0;
               ready_d = 1'b0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            // In priority mode only the first enabled channel contributes.
            if (sel_q[idx_q] && (mode_q || !found_q)) begin
               acc_d = acc_q + cur_ext;
            end
            if (sel_q[idx_q]) begin
               found_d = 1'b1;
            end
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               state_d = SCALE;
            end
         end
         SCALE: begin
            level_d     = sat_val;
            level_vld_d = 1'b1;
            ready_d     = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Offset-binary level drives a first-order sigma-delta; the carry is the bit stream.
   assign pdm_sum   = {1'b0, pdm_acc_q} + {1'b0, ~level_q[SAMPLE_WIDTH-1], level_q[SAMPLE_WIDTH-2:0]};
   assign pdm_acc_d = pdm_sum[SAMPLE_WIDTH-1:0];
   assign pdm_d     = pdm_sum[SAMPLE_WIDTH];

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         acc_q       <= '0;
         found_q     <= 1'b0;
         data_q      <= '0;
         sel_q       <= '0;
         mode_q      <= 1'b0;
         gain_q      <= '0;
         ready_q     <= 1'b1;
         level_q     <= '0;
         level_vld_q <= 1'b0;
         pdm_acc_q   <= '0;
         pdm_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         found_q     <= found_d;
         data_q      <= data_d;
         sel_q       <= sel_d;
         mode_q      <= mode_d;
         gain_q      <= gain_d;
         ready_q     <= ready_d;
         level_q     <= level_d;
         level_vld_q <= level_vld_d;
         pdm_acc_q   <= pdm_acc_d;
         pdm_q       <= pdm_d;
      end
   end

`ifdef MIXER_CLIP_DETECT_EN
   logic clip_q, clip_d;

   assign clip_d = (state_q == SCALE) && (sat_hi || sat_lo);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         clip_q <= 1'b0;
      end else begin
         clip_q <= clip_d;
      end
   end

   assign clip_out = clip_q;
`endif

   assign audio_ready_out = ready_q;
   assign level_out       = level_q;
   assign level_valid_out = level_vld_q;
   assign pdm_out         = pdm_q;

endmodule

// File: tb/tb_audio_playback_mixer.sv
// Scoreboard bench for audio_playback_mixer (4 channels, 16-bit samples).
module tb_audio_playback_mixer;

   logic             clk_in;
   logic             rst_in;
   logic [3:0][15:0] audio_data_in;
   logic             audio_valid_in;
   logic             audio_ready_out;
   logic [3:0]       sel_in;
   logic             mode_in;
   logic [2:0]       gain_in;
   logic [15:0]      level_out;
   logic             level_valid_out;
   logic             pdm_out;
`ifdef MIXER_CLIP_DETECT_EN
   logic             clip_out;
`endif

   audio_playback_mixer #(.NUM_CHANNELS(4), .SAMPLE_WIDTH(16)) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .audio_data_in   (audio_data_in),
      .audio_valid_in  (audio_valid_in),
      .audio_ready_out (audio_ready_out),
      .sel_in          (sel_in),
      .mode_in         (mode_in),
      .gain_in         (gain_in),
      .level_out       (level_out),
      .level_valid_out (level_valid_out),
      .pdm_out         (pdm_out)
`ifdef MIXER_CLIP_DETECT_EN
      ,
      .clip_out        (clip_out)
`endif
   );

   typedef struct {
      logic [15:0] lvl;
      logic        clip;
   } exp_t;

   exp_t exp_q[$];
   int   tests  = 0;
   int   fails  = 0;
   int   pulses = 0;

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Monitor: every output pulse is matched against the oldest expectation.
   always @(negedge clk_in) begin
      exp_t e;
      if (level_valid_out === 1'b1) begin
         pulses++;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_pulse: got level %0d, expected no pulse", $signed(level_out));
         end else begin
            e = exp_q.pop_front();
            check("level_out", $signed(level_out), $signed(e.lvl));
`ifdef MIXER_CLIP_DETECT_EN
            check("clip_out", {31'd0, clip_out}, {31'd0, e.clip});
`endif
         end
      end
   end

   task automatic send(input logic m, input logic [3:0] s, input logic [2:0] g,
                       input logic [15:0] c0, input logic [15:0] c1,
                       input logic [15:0] c2, input logic [15:0] c3,
                       input logic [15:0] el, input logic ec);
      exp_t e;
      int   n;
      n = 0;
      while (!audio_ready_out && n < 50) begin
         @(negedge clk_in);
         n++;
      end
      if (!audio_ready_out) check("ready_timeout", 0, 1);
      audio_data_in[0] = c0;
      audio_data_in[1] = c1;
      audio_data_in[2] = c2;
      audio_data_in[3] = c3;
      sel_in  = s;
      mode_in = m;
      gain_in = g;
      audio_valid_in = 1'b1;
      e.lvl  = el;
      e.clip = ec;
      exp_q.push_back(e);
      @(posedge clk_in);
      #1;
      // Scramble inputs after the accept edge; the result must not change.
      audio_valid_in = 1'b0;
      for (int i = 0; i < 4; i++) audio_data_in[i] = 16'($urandom);
      sel_in  = ~s;
      mode_in = ~m;
      gain_in = ~g;
      n = 0;
      while (level_valid_out !== 1'b1 && n < 20) begin
         @(posedge clk_in);
         #1;
         n++;
      end
      check("latency", n, 5);
   endtask

   initial begin
      int ones, alt_err, accepts, low_cnt, p0;
      rst_in = 1'b1;
      audio_valid_in = 1'b0;
      audio_data_in = '0;
      sel_in = '0;
      mode_in = 1'b0;
      gain_in = '0;
      repeat (3) @(negedge clk_in);
      check("rst_ready", {31'd0, audio_ready_out}, 1);
      check("rst_level", $signed(level_out), 0);
      check("rst_valid", {31'd0, level_valid_out}, 0);
      check("rst_pdm", {31'd0, pdm_out}, 0);
      rst_in = 1'b0;

      ones = 0;
      alt_err = 0;
      for (int i = 0; i < 256; i++) begin
         @(posedge clk_in);
         #1;
         if (pdm_out) ones++;
         if (pdm_out !== 1'(i & 1)) alt_err++;
      end
      check("pdm_ones", ones, 128);
      check("pdm_alternate_errors", alt_err, 0);

      @(negedge clk_in);
      send(1'b0, 4'b0110, 3'd0, 16'sd7, 16'sd1000, -16'sd5, 16'sd3, 16'sd1000, 1'b0);
      send(1'b1, 4'b1111, 3'd0, 16'sd16384, 16'sd16384, 16'sd16384, 16'sd16384, 16'sd16384, 1'b0);
      send(1'b1, 4'b1111, 3'd1, 16'sd16384, 16'sd16384, 16'sd16384, 16'sd16384, 16'sd32767, 1'b1);
      send(1'b1, 4'b1111, 3'd3, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b1);
      send(1'b1, 4'b0000, 3'd5, 16'sd100, 16'sd200, 16'sd300, 16'sd400, 16'sd0, 1'b0);
      send(1'b0, 4'b0000, 3'd2, 16'sd100, 16'sd200, 16'sd300, 16'sd400, 16'sd0, 1'b0);
      send(1'b0, 4'b1000, 3'd2, 16'sd1, 16'sd2, 16'sd3, -16'sd300, -16'sd1200, 1'b0);
      send(1'b1, 4'b0101, 3'd0, 16'sd100, 16'sd999, 16'sd300, 16'sd999, 16'sd100, 1'b0);
      send(1'b1, 4'b0011, 3'd0, -16'sd3, 16'sd0, 16'sd50, 16'sd50, -16'sd1, 1'b0);
      send(1'b0, 4'b1100, 3'd7, 16'sd9, 16'sd9, 16'sd300, 16'sd5, 16'sd32767, 1'b1);
      send(1'b0, 4'b0001, 3'd7, -16'sd256, 16'sd9, 16'sd9, 16'sd9, 16'h8000, 1'b0);
      send(1'b0, 4'b0001, 3'd0, 16'sd32767, 16'sd1, 16'sd1, 16'sd1, 16'sd32767, 1'b0);

      // Held valid: one accept every six cycles.
      @(negedge clk_in);
      audio_data_in[0] = 16'sd42;
      sel_in  = 4'b0001;
      mode_in = 1'b0;
      gain_in = 3'd0;
      audio_valid_in = 1'b1;
      accepts = 0;
      low_cnt = 0;
      for (int i = 0; i < 60; i++) begin
         if (audio_ready_out) begin
            exp_t e;
            accepts++;
            e.lvl  = 16'sd42;
            e.clip = 1'b0;
            exp_q.push_back(e);
         end else begin
            low_cnt++;
         end
         @(negedge clk_in);
      end
      audio_valid_in = 1'b0;
      check("b2b_accepts", accepts, 10);
      check("b2b_ready_low", low_cnt, 50);
      repeat (10) @(negedge clk_in);
      check("b2b_drained", exp_q.size(), 0);

      // Reset in the middle of an accumulation aborts it silently.
      p0 = pulses;
      audio_data_in[0] = 16'sd77;
      audio_valid_in = 1'b1;
      @(posedge clk_in);
      #1;
      audio_valid_in = 1'b0;
      @(negedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b0;
      @(posedge clk_in);
      #1;
      check("abort_level", $signed(level_out), 0);
      check("abort_ready", {31'd0, audio_ready_out}, 1);
      repeat (10) @(negedge clk_in);
      check("abort_no_pulse", pulses, p0);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/audio_playback_mixer.md
AUDIO_PLAYBACK_MIXER -- requirements
Module: audio_playback_mixer

Interface
REQ-001 Parameter NUM_CHANNELS, default 4, number of mic channels; SHALL be a power of two, 2..16.
REQ-002 Parameter SAMPLE_WIDTH, default 16, signed sample width in bits.
REQ-003 clk_in  input  1  sole clock; all state on rising edge.
REQ-004 rst_in  input  1  reset, asynchronous, active-high.
REQ-005 audio_data_in  input  NUM_CHANNELS x SAMPLE_WIDTH  signed samples, one per channel.
REQ-006 audio_valid_in  input  1  sample set valid.
REQ-007 audio_ready_out  output  1  mixer can accept a sample set.
REQ-008 sel_in  input  NUM_CHANNELS  channel enable mask.
REQ-009 mode_in  input  1  0 = priority select, 1 = average mix.
REQ-010 gain_in  input  3  left-shift gain, 0..7.
REQ-011 level_out  output  SAMPLE_WIDTH  signed playback level, held between updates.
REQ-012 level_valid_out  output  1  one-cycle pulse on each level_out update.
REQ-013 pdm_out  output  1  first-order sigma-delta PDM of level_out.

Function
REQ-014 Accept on rising edge with audio_valid_in && audio_ready_out; SHALL snapshot all channels, sel_in, mode_in, gain_in at that edge; later input changes do not affect the result.
REQ-015 FSM states IDLE, ACCUM, SCALE; IDLE->ACCUM on accept; ACCUM runs exactly NUM_CHANNELS cycles, one channel per cycle, index 0 upward; ACCUM->SCALE after last index; SCALE->IDLE unconditionally.
REQ-016 audio_ready_out SHALL be registered, 1 only in IDLE; audio_valid_in outside IDLE is ignored, never queued.
REQ-017 Accumulator signed, SAMPLE_WIDTH+log2(NUM_CHANNELS)+8 bits, cleared on accept.
REQ-018 mode 0: accumulate only the lowest-index enabled channel; result = that sample << gain.
REQ-019 mode 1: accumulate every enabled channel; result = (sum >>> log2(NUM_CHANNELS)) << gain, arithmetic shift.
REQ-020 sel mask all-zero: result 0 in either mode.
REQ-021 Result saturates to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1]; no wrap.
REQ-022 SCALE edge registers level_out and asserts level_valid_out for one cycle; latency NUM_CHANNELS+1 edges after the accepting edge; audio_ready_out returns to 1 on that same edge.
REQ-023 Back-to-back: held audio_valid_in yields one accept every NUM_CHANNELS+2 cycles.
REQ-024 PDM: each cycle, SAMPLE_WIDTH-bit accumulator adds offset-binary level_out (MSB inverted); pdm_out registers the carry.

Reset
REQ-025 rst_in asserted: state IDLE, accumulators 0, level_out 0, level_valid_out 0, pdm_out 0, audio_ready_out 1, clip_out 0 when present.
REQ-026 Reset mid-ACCUM or mid-SCALE SHALL abort the operation with no level_valid_out pulse.

Configuration
REQ-027 Macro MIXER_CLIP_DETECT_EN defined: output clip_out (1 bit) pulses high with level_valid_out when REQ-021 saturation occurred.
REQ-028 MIXER_CLIP_DETECT_EN undefined: clip_out port and logic absent; saturation behaviour unchanged.

Verification (NUM_CHANNELS=4, SAMPLE_WIDTH=16)
REQ-029 mode 0, sel 4'b0110, ch1=1000, ch2=-5, gain 0 -> level_out=1000, level_valid_out 5 edges after accept, clip_out 0.
REQ-030 mode 1, sel 4'b1111, all ch=16384: gain 0 -> 16384; gain 1 -> 32767 with clip_out pulse.
REQ-031 mode 1, sel 4'b1111, all ch=-32768, gain 3 -> -32768, clip_out pulse; sel 4'b0000 -> 0.
REQ-032 audio_valid_in held high 60 cycles -> exactly 10 accepts, audio_ready_out low 5 of every 6 cycles.
REQ-033 rst_in pulsed during ACCUM -> no level_valid_out, level_out 0, audio_ready_out 1 next cycle.
REQ-034 level_out 0 for 256 cycles from reset -> pdm_out alternates 0,1, exactly 128 ones.
